vga_timing: RTL

- Source end of the vga_if stream: generates hcount/vcount, hsync/vsync and hblnk/vblnk for every pixel slot.
- All downstream draw stages consume this stream and register it one stage per module.
- Sits at the head of the video pipeline, fed by the pixel clock domain; drives rgb as 0 so the first draw stage fills the active area.
- Default timing is 800x600 @ 60 Hz (40 MHz pixel clock).

---
 rtl/vga_timing_if.sv | 16 +
 rtl/vga_timing.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Video stream bundle carried between the timing source and every draw stage.
// The timing generator drives it through the 'out' (or 'master') modport and
// consumers read it through 'slave'.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// Head of the video pipeline: walks the raster one pixel slot per pix_en step
// and publishes counts, sync and blanking flags, all registered together.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_timing #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  vga_if.out   out,
  output logic frame_start,
  output logic line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Window edges are kept 12 bits wide so a window ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_BLNK_START = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_BLNK_START = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  // The 11-bit counters cannot address a raster larger than 2048 in either direction.
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        hblnk_nxt;
  logic        vblnk_nxt;

  // Next raster position: step along the line, wrapping into the next line and frame.
  always_comb begin
    h_wrap     = (hcount == H_LAST);
    v_wrap     = h_wrap && (vcount == V_LAST);
    hcount_nxt = h_wrap ? 11'd0 : hcount + 11'd1;
    vcount_nxt = vcount;
    if (h_wrap) begin
      vcount_nxt = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
    end
  end

  // Flags are derived from the next counts so they land in the same register stage as the counts.
  always_comb begin
    hblnk_nxt = ({1'b0, hcount_nxt} >= H_BLNK_START);
    vblnk_nxt = ({1'b0, vcount_nxt} >= V_BLNK_START);
    hsync_nxt = ~HSYNC_POL;
    vsync_nxt = ~VSYNC_POL;
    if ({1'b0, hcount_nxt} >= H_SYNC_START && {1'b0, hcount_nxt} < H_SYNC_END) begin
      hsync_nxt = HSYNC_POL;
    end
    if ({1'b0, vcount_nxt} >= V_SYNC_START && {1'b0, vcount_nxt} < V_SYNC_END) begin
      vsync_nxt = VSYNC_POL;
    end
  end

  // Output register: advance on pix_en, otherwise hold everything except the one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter for animation, bumped on the same step that raises frame_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
    end else if (pix_en && v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  assign out.hcount = hcount;
  assign out.vcount = vcount;
  assign out.hsync  = hsync;
  assign out.vsync  = vsync;
  assign out.hblnk  = hblnk;
  assign out.vblnk  = vblnk;
  assign out.rgb    = 12'h000;

endmodule
